// File: rtl/regfile_sb_if.sv
// Decode-stage bus for regfile_sb: write port, two read ports, reservation
// port and the scoreboard status outputs.
interface regfile_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_a_i;
    logic [ADDR_W-1:0] rd_addr_b_i;
    logic [DATA_W-1:0] rd_a_o;
    logic [DATA_W-1:0] rd_b_o;
    logic              rsv_en_i;
    logic [ADDR_W-1:0] rsv_addr_i;
    logic              busy_a_o;
    logic              busy_b_o;
    logic              hazard_o;
    logic [DEPTH-1:0]  busy_vec_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i,
        output rd_en_i, rd_addr_a_i, rd_addr_b_i,
        output rsv_en_i, rsv_addr_i,
        input  rd_a_o, rd_b_o, busy_a_o, busy_b_o, hazard_o, busy_vec_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i,
        input  rd_en_i, rd_addr_a_i, rd_addr_b_i,
        input  rsv_en_i, rsv_addr_i,
        output rd_a_o, rd_b_o, busy_a_o, busy_b_o, hazard_o, busy_vec_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file (reg 0 hardwired to zero) with a one-bit-per-register
// pending-write scoreboard and optional same-cycle write forwarding.
module regfile_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b1
) (
    input logic        clk_i,
    input logic        rst_i,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_wr_ok;
    logic              w_fwd_a;
    logic              w_fwd_b;

    assign w_wr_ok = bus.wr_en_i && (bus.wr_addr_i != '0);

    // Reservation is applied after the clear so a younger producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wr_en_i)
            w_busy_nxt[bus.wr_addr_i] = 1'b0;
        if (bus.rsv_en_i)
            w_busy_nxt[bus.rsv_addr_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Forwarding is gated by reset so outputs read zero while rst_i is high.
    assign w_fwd_a = BYPASS && !rst_i && w_wr_ok && (bus.wr_addr_i == bus.rd_addr_a_i);
    assign w_fwd_b = BYPASS && !rst_i && w_wr_ok && (bus.wr_addr_i == bus.rd_addr_b_i);

    always_comb begin
        bus.rd_a_o = '0;
        bus.rd_b_o = '0;
        if (bus.rd_en_i) begin
            if (w_fwd_a)
                bus.rd_a_o = bus.wr_data_i;
            else if (bus.rd_addr_a_i != '0)
                bus.rd_a_o = r_mem[bus.rd_addr_a_i];
            if (w_fwd_b)
                bus.rd_b_o = bus.wr_data_i;
            else if (bus.rd_addr_b_i != '0)
                bus.rd_b_o = r_mem[bus.rd_addr_b_i];
        end
    end

    assign bus.busy_a_o   = bus.rd_en_i & r_busy[bus.rd_addr_a_i] & ~w_fwd_a;
    assign bus.busy_b_o   = bus.rd_en_i & r_busy[bus.rd_addr_b_i] & ~w_fwd_b;
    assign bus.hazard_o   = bus.busy_a_o | bus.busy_b_o;
    assign bus.busy_vec_o = r_busy;
endmodule
